// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader.
//
// Receives a framed byte stream (16-bit big-endian word count, N big-endian
// 32-bit words, one XOR checksum byte), writes the words into instruction
// memory and releases the CPU from reset once a full frame with a correct
// checksum has been loaded. Malformed frames or stalled transfers end in a
// sticky error state.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx_valid   in   byte-stream valid
//   rx_data    in   byte-stream data [7:0]
//   rx_ready   out  loader can accept a byte
//   imem_we    out  instruction-memory write strobe, one cycle per word
//   imem_addr  out  word address for the write [ADDR_W-1:0]
//   imem_wdata out  word to write [31:0]
//   cpu_rst    out  CPU reset, high until the load succeeds
//   done       out  load completed successfully (sticky)
//   err        out  load failed (sticky)
//   err_code   out  0 none, 1 length overflow, 2 checksum, 3 timeout
module imem_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // One extra index bit so that a full memory (N = 2^ADDR_W) is loadable.
    localparam int unsigned IdxW = ADDR_W + 1;
    localparam logic [32:0] CapWide = 33'(1) << ADDR_W;

    localparam logic [1:0] ErrLen     = 2'd1;
    localparam logic [1:0] ErrCsum    = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [IdxW-1:0]   len_q, len_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [1:0]        byte_q, byte_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       timer_q, timer_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              accept;
    logic              timer_on;
    logic [15:0]       n_full;
    logic [IdxW-1:0]   idx_next;

    assign accept   = rx_valid & rx_ready;
    assign n_full   = {len_hi_q, rx_data};
    assign idx_next = idx_q + IdxW'(1);

    always_comb begin
        rx_ready = 1'b0;
        timer_on = 1'b0;
        unique case (state_q)
            StLenHi: rx_ready = 1'b1;
            StLenLo, StData, StCsum: begin
                rx_ready = 1'b1;
                timer_on = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            rx_ready = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        timer_d   = 32'd0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        cpu_rst_d = cpu_rst_q;

        if (accept && state_q != StCsum) begin
            csum_d = csum_q ^ rx_data;
        end

        if (timer_on && !accept) begin
            timer_d = timer_q + 32'd1;
        end

        unique case (state_q)
            StLenHi: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    if (33'(n_full) > CapWide) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = ErrLen;
                    end else if (n_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        len_d   = IdxW'(n_full);
                        idx_d   = '0;
                        byte_d  = 2'd0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = {shift_q, rx_data};
                        idx_d   = idx_next;
                        byte_d  = 2'd0;
                        if (idx_next == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], rx_data};
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = ErrCsum;
                    end
                end
            end
            StDone: ;
            StErr: ;
            default: ;
        endcase

        // An accept clears the timer, so it always beats an expiring timeout.
        if (TIMEOUT != 0 && timer_on && !accept && timer_d == TIMEOUT) begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = ErrTimeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLenHi;
            len_hi_q  <= 8'd0;
            len_q     <= '0;
            idx_q     <= '0;
            byte_q    <= 2'd0;
            shift_q   <= 24'd0;
            csum_q    <= 8'd0;
            timer_q   <= 32'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            csum_q    <= csum_d;
            timer_q   <= timer_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    // Suppress a write still pending from before a reset so none lands on the reset cycle.
    assign imem_we    = we_q & ~rst;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=8, TIMEOUT=16).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    // Two-word frame body; correct checksum 8B follows.
    logic [7:0] body [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                              8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};

    imem_loader #(
        .ADDR_W  (8),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_for_byte", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        check("rx_ready_in_rst", {31'd0, rx_ready}, 32'd0);
        rst = 1'b0;
        #1;
    endtask

    task automatic send_body(input int max_gap);
        for (int i = 0; i < 10; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(body[i]);
        end
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_wr_count"}, wr_addr.size(), 32'd2);
        if (wr_addr.size() >= 2) begin
            check({tag, "_addr0"}, {24'd0, wr_addr[0]}, 32'd0);
            check({tag, "_data0"}, wr_data[0], 32'h2008_0005);
            check({tag, "_addr1"}, {24'd0, wr_addr[1]}, 32'd1);
            check({tag, "_data1"}, wr_data[1], 32'hAC08_0000);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rx_ready_in_initial_rst", {31'd0, rx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Two-word frame, continuous valid; checksum lands on the final write pulse.
        send_body(0);
        check("ok_done_before_csum", {31'd0, done}, 32'd0);
        send_byte(8'h8B);
        check("ok_done", {31'd0, done}, 32'd1);
        check("ok_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("ok_err", {31'd0, err}, 32'd0);
        check("ok_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check_two_writes("ok");
        check("ok_done_sticky", {31'd0, done}, 32'd1);

        // Bad checksum.
        do_reset();
        send_body(0);
        send_byte(8'h8A);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_err_code", {30'd0, err_code}, 32'd2);
        check("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check_two_writes("bad");

        // N = 257 exceeds 256-word capacity.
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        check("len_err", {31'd0, err}, 32'd1);
        check("len_err_code", {30'd0, err_code}, 32'd1);
        check("len_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("len_wr_count", wr_addr.size(), 32'd0);

        // Timeout 16 cycles after the last accepted byte.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (15) @(negedge clk);
        check("to_err_early", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_err_code", {30'd0, err_code}, 32'd3);
        check("to_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("to_wr_count", wr_addr.size(), 32'd0);

        // Empty frame.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("empty_err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);
        check("empty_wr_count", wr_addr.size(), 32'd0);

        // Random valid gaps, each well under the timeout.
        do_reset();
        send_body(12);
        repeat ($urandom_range(0, 12)) @(negedge clk);
        send_byte(8'h8B);
        check("gap_done", {31'd0, done}, 32'd1);
        check("gap_err", {31'd0, err}, 32'd0);
        repeat (3) @(negedge clk);
        check_two_writes("gap");

        // Reset after two data bytes, then a full clean frame.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h08);
        do_reset();
        send_body(0);
        send_byte(8'h8B);
        check("mid_done", {31'd0, done}, 32'd1);
        check("mid_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        repeat (3) @(negedge clk);
        check_two_writes("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction loader upstream of the CPU/ROM/RAM top.
- Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into instruction memory.
- Holds the CPU in reset until a complete frame with a correct checksum has been loaded.
- Sticky error reporting for malformed frames or stalled transfers.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- TIMEOUT, 1000000, maximum idle cycles between accepted bytes once a frame has started; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data.
- rx_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to CPU; high until load succeeds.
- done  output  1  load completed successfully; sticky.
- err  output  1  load failed; sticky.
- err_code  output  2  0 none, 1 length overflow, 2 checksum, 3 timeout.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset values: state LEN_HI, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, done 0, err 0, err_code 0, timer 0, checksum 0. While rst is high, rx_ready is 0.
- Frame format:
  - Length N: 16-bit big-endian, sent as LEN_HI byte then LEN_LO byte.
  - N words: 4 bytes each, first byte goes to bits [31:24].
  - 1 checksum byte: XOR of every preceding frame byte, length bytes included.
- A byte is accepted on a cycle where rx_valid and rx_ready are both high.
- rx_ready = 1 in states LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERR.
- Every accepted byte is XORed into the running checksum, except the checksum byte itself.
- State transitions:
  - LEN_HI: on accept, capture N[15:8] and go to LEN_LO.
  - LEN_LO: on accept, capture N[7:0], then:
    - if N > 2^ADDR_W, go to ERR with code 1;
    - else if N == 0, go to CSUM;
    - else go to DATA with word index 0 and byte index 0.
  - DATA: shift each accepted byte into the word. When the 4th byte is accepted, on the next cycle imem_we=1, imem_addr=word index, imem_wdata=assembled word. The word index then increments; after word N-1 go to CSUM.
  - CSUM: on accept, go to DONE if the byte equals the accumulated XOR, else ERR with code 2.
  - DONE: done=1 and cpu_rst=0, both registered (asserted the cycle after the checksum byte is accepted). Held until rst.
  - ERR: err=1, err_code latched, cpu_rst stays 1. Held until rst.
- Write timing:
  - imem_we is high for exactly one cycle per word.
  - imem_addr and imem_wdata hold their last values between writes.
  - A checksum byte accepted in the same cycle as the final imem_we pulse is legal.
- Timeout:
  - The timer counts cycles without an accepted byte in LEN_LO, DATA and CSUM; it is cleared on every accept and stays 0 in LEN_HI.
  - If TIMEOUT != 0 and the timer reaches TIMEOUT, go to ERR with code 3.
  - If a byte is accepted in the same cycle the timer would reach TIMEOUT, the accept wins.
- rx_valid gaps of any length are tolerated, subject to the timeout.
- rst mid-frame: the partial frame is discarded and there is no write on the reset cycle or after it. Memory contents already written are left as-is.
- Word index width: ADDR_W+1 bits, so N = 2^ADDR_W is loadable.

Test Plan:
- Two-word load, bytes 00 02 20 08 00 05 AC 08 00 00 8B, rx_valid continuous -> imem_we pulses: addr 0 with 0x20080005, then addr 1 with 0xAC080000. done=1 and cpu_rst=0 one cycle after the 8B byte is accepted; rx_ready=0 thereafter.
- Same frame with checksum 8A -> no change to the two writes; err=1, err_code=2, cpu_rst stays 1, done=0, rx_ready=0.
- ADDR_W=8, length bytes 01 01 (N=257) -> err=1, err_code=1 the cycle after LEN_LO is accepted; no imem_we ever.
- TIMEOUT=16, send 00 01 20 then hold rx_valid=0 -> err_code=3 asserted exactly 16 cycles after the 0x20 accept; no imem_we.
- N=0 frame 00 00 00 -> done=1, cpu_rst=0, zero imem_we pulses. Randomised rx_valid gaps (each < TIMEOUT) on the two-word frame -> identical writes and done.
- rst asserted for one cycle after 2 of 4 data bytes, then the full two-word frame is sent -> no write from the partial frame; normal load completes with done=1.
